// File: rtl/glitch_pkg.sv
// Shared types and default widths for the glitch sequencer and its command decoder.
package glitch_pkg;
  localparam int GLITCH_CNT_W = 32;
  localparam int GLITCH_REP_W = 8;
  localparam int GLITCH_SEL_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } glitch_state_t;
endpackage

// File: rtl/glitch_sequencer_trig_sync.sv
// Trigger pin synchroniser with a registered, polarity-selectable edge detector.
module trig_sync (
  input  logic clk,
  input  logic reset,
  input  logic trig_in,
  input  logic rise_sel,
  input  logic mask,
  output logic edge_det
);
  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      prev     <= 1'b0;
      edge_det <= 1'b0;
    end else begin
      s1   <= trig_in;
      s2   <= s1;
      prev <= s2;
      // mask drops an edge coincident with arm so a stale level never fires
      edge_det <= mask ? 1'b0 : (rise_sel ? (s2 & ~prev) : (~s2 & prev));
    end
  end
endmodule

// File: rtl/glitch_sequencer.sv
// Armed multi-pulse glitch generator: trigger -> delay -> N pulses of width/gap.
// Optional ARM_TIMEOUT_EN: ARMED gives up after cfg_timeout cycles (0 = forever).
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int CNT_W     = GLITCH_CNT_W,
  parameter int REP_W     = GLITCH_REP_W,
  parameter int SEL_W     = GLITCH_SEL_W,
  parameter int TIMEOUT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     cfg_delay,
  input  logic [CNT_W-1:0]     cfg_width,
  input  logic [CNT_W-1:0]     cfg_gap,
  input  logic [REP_W-1:0]     cfg_count,
  input  logic [SEL_W-1:0]     cfg_sel,
  input  logic                 cfg_edge,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig_in,
  output logic                 o_glitch,
  output logic [SEL_W-1:0]     o_sel,
  output logic                 armed,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [REP_W-1:0]     pulse_idx
);
  glitch_state_t    state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, delay_q, width_m1, gap_m1;
  logic [REP_W-1:0] count_m1, idx_n;
  logic [SEL_W-1:0] sel_n;
  logic             rise_q, edge_det, arm_ok, tmo_hit;

  function automatic logic [CNT_W-1:0] cnt_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign arm_ok = arm && !abort && (state == ST_IDLE);

  trig_sync u_trig (
    .clk      (clk),
    .reset    (reset),
    .trig_in  (trig_in),
    .rise_sel (rise_q),
    .mask     (arm_ok),
    .edge_det (edge_det)
  );

`ifdef ARM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 tmo_inf;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt    <= '0;
      tmo_inf <= 1'b1;
    end else if (arm_ok) begin
      tcnt    <= cfg_timeout - 1'b1;
      tmo_inf <= (cfg_timeout == '0);
    end else if (state == ST_ARMED && tcnt != '0) begin
      tcnt <= tcnt - 1'b1;
    end
  end

  // a trigger landing on the last armed cycle takes priority over the timeout
  assign tmo_hit   = (state == ST_ARMED) && !tmo_inf && (tcnt == '0) && !edge_det && !abort;
  assign timed_out = tmo_hit;
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign tmo_hit   = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = pulse_idx;
    sel_n   = o_sel;
    case (state)
      ST_IDLE: if (arm_ok) begin
        state_n = ST_ARMED;
        sel_n   = cfg_sel;
        idx_n   = '0;
      end
      ST_ARMED: begin
        if (edge_det) begin
          if (delay_q == '0) begin
            state_n = ST_PULSE;
            cnt_n   = width_m1;
          end else begin
            state_n = ST_DELAY;
            cnt_n   = delay_q - 1'b1;
          end
        end else if (tmo_hit) begin
          state_n = ST_IDLE;
          sel_n   = '0;
        end
      end
      ST_DELAY: begin
        if (cnt == '0) begin
          state_n = ST_PULSE;
          cnt_n   = width_m1;
        end else cnt_n = cnt - 1'b1;
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          if (pulse_idx == count_m1) begin
            state_n = ST_DONE;
            sel_n   = '0;
          end else begin
            state_n = ST_GAP;
            cnt_n   = gap_m1;
            idx_n   = pulse_idx + 1'b1;
          end
        end else cnt_n = cnt - 1'b1;
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_n = ST_PULSE;
          cnt_n   = width_m1;
        end else cnt_n = cnt - 1'b1;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        idx_n   = '0;
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      sel_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pulse_idx <= '0;
      o_sel     <= '0;
      o_glitch  <= 1'b0;
      delay_q   <= '0;
      width_m1  <= '0;
      gap_m1    <= '0;
      count_m1  <= '0;
      rise_q    <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pulse_idx <= idx_n;
      o_sel     <= sel_n;
      o_glitch  <= (state_n == ST_PULSE);
      if (arm_ok) begin
        delay_q  <= cfg_delay;
        width_m1 <= cnt_m1(cfg_width);
        gap_m1   <= cnt_m1(cfg_gap);
        count_m1 <= (cfg_count == '0) ? '0 : cfg_count - 1'b1;
        rise_q   <= cfg_edge;
      end
    end
  end

  assign armed = (state == ST_ARMED);
  assign busy  = (state == ST_DELAY) || (state == ST_PULSE) || (state == ST_GAP);
  assign done  = (state == ST_DONE);
endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: vector table of full sequences plus corner-case sequences.
module tb_glitch_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cfg_delay = '0, cfg_width = '0, cfg_gap = '0, cfg_timeout = '0;
  logic [7:0]  cfg_count = '0;
  logic [2:0]  cfg_sel = '0;
  logic        cfg_edge = 1'b1, arm = 1'b0, abort = 1'b0, trig_in = 1'b0;
  logic        o_glitch, armed, busy, done, timed_out;
  logic [2:0]  o_sel;
  logic [7:0]  pulse_idx;

  int n_chk = 0;
  int n_fail = 0;

  glitch_sequencer dut (
    .clk(clk), .reset(reset), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_sel(cfg_sel), .cfg_edge(cfg_edge),
    .cfg_timeout(cfg_timeout), .arm(arm), .abort(abort), .trig_in(trig_in),
    .o_glitch(o_glitch), .o_sel(o_sel), .armed(armed), .busy(busy), .done(done),
    .timed_out(timed_out), .pulse_idx(pulse_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] delay, width, gap;
    logic [7:0]  count;
    logic [2:0]  sel;
    logic        rise;
    int          exp_first, exp_high, exp_done;
  } vec_t;

  vec_t vecs[5];

  // inputs change 1 time unit after the rising edge, outputs are sampled 3 later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic g, input logic [2:0] s,
                         input logic a, input logic b, input logic d);
    chk({tag, " glitch"}, o_glitch, g);
    chk({tag, " sel"}, o_sel, s);
    chk({tag, " armed"}, armed, a);
    chk({tag, " busy"}, busy, b);
    chk({tag, " done"}, done, d);
    chk({tag, " timed_out"}, timed_out, 0);
  endtask

  task automatic set_cfg(input logic [31:0] d, input logic [31:0] w, input logic [31:0] g,
                         input logic [7:0] c, input logic [2:0] s, input logic e,
                         input logic [31:0] tmo);
    cfg_delay = d; cfg_width = w; cfg_gap = g; cfg_count = c;
    cfg_sel = s; cfg_edge = e; cfg_timeout = tmo;
  endtask

  task automatic idle_trig(input logic lvl);
    arm = 1'b0; abort = 1'b0; trig_in = lvl;
    repeat (4) tick();
  endtask

  vec_t v;
  int   wp, gp, cp, rel, act_high;
  logic exp_g;
  string tag;

  initial begin
    vecs[0] = '{delay:10, width:5, gap:0, count:1, sel:3'b101, rise:1'b1, exp_first:16, exp_high:5, exp_done:21};
    vecs[1] = '{delay:0,  width:2, gap:3, count:4, sel:3'b010, rise:1'b1, exp_first:6,  exp_high:8, exp_done:23};
    vecs[2] = '{delay:0,  width:0, gap:0, count:0, sel:3'b111, rise:1'b0, exp_first:6,  exp_high:1, exp_done:7};
    vecs[3] = '{delay:1,  width:1, gap:1, count:3, sel:3'b001, rise:1'b1, exp_first:7,  exp_high:3, exp_done:12};
    vecs[4] = '{delay:2,  width:3, gap:0, count:2, sel:3'b100, rise:1'b0, exp_first:8,  exp_high:6, exp_done:15};

    repeat (3) tick();
    #3;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset idx", pulse_idx, 0);
    reset = 1'b0;

    // table: arm at t=0, pin edge at t=2 (detected t=5), junk cfg at t=1
    for (int i = 0; i < 5; i++) begin
      v  = vecs[i];
      wp = (v.width == 0) ? 1 : int'(v.width);
      gp = (v.gap == 0) ? 1 : int'(v.gap);
      cp = (v.count == 0) ? 1 : int'(v.count);
      act_high = 0;
      idle_trig(~v.rise);
      for (int t = 0; t <= v.exp_done + 2; t++) begin
        tick();
        arm = (t == 0);
        if (t == 0) set_cfg(v.delay, v.width, v.gap, v.count, v.sel, v.rise, 0);
        if (t == 1) set_cfg(3, 0, 7, 9, 3'b110, ~v.rise, 0);
        if (t == 2) trig_in = v.rise;
        #3;
        rel   = t - v.exp_first;
        exp_g = (rel >= 0) && (rel / (wp + gp) < cp) && (rel % (wp + gp) < wp);
        tag   = $sformatf("vec%0d t%0d", i, t);
        chk_out(tag, exp_g, (t >= 1 && t < v.exp_done) ? v.sel : 3'b000,
                (t >= 1 && t <= 5), (t >= 6 && t < v.exp_done), (t == v.exp_done));
        if (exp_g) chk({tag, " idx"}, pulse_idx, rel / (wp + gp));
        if (o_glitch) act_high++;
      end
      chk($sformatf("vec%0d high_cycles", i), act_high, v.exp_high);
    end

    // abort in 3rd cycle of a 10-cycle pulse, then a fresh edge must not fire
    idle_trig(0);
    for (int t = 0; t <= 26; t++) begin
      tick();
      arm   = (t == 0);
      abort = (t == 8);
      if (t == 0) set_cfg(0, 10, 1, 1, 3'b101, 1, 0);
      if (t == 2) trig_in = 1;
      if (t == 12) trig_in = 0;
      if (t == 16) trig_in = 1;
      #3;
      if (t == 8) chk("abort pre glitch", o_glitch, 1);
      if (t >= 9) chk_out($sformatf("abort t%0d", t), 0, 0, 0, 0, 0);
      if (t == 9) chk("abort idx", pulse_idx, 0);
    end

    // arm and abort together: nothing latched, trigger ignored
    idle_trig(0);
    for (int t = 0; t <= 14; t++) begin
      tick();
      arm   = (t == 0);
      abort = (t == 0);
      if (t == 0) set_cfg(0, 1, 1, 1, 3'b111, 1, 0);
      if (t == 2) trig_in = 1;
      #3;
      if (t >= 1) chk_out($sformatf("armabort t%0d", t), 0, 0, 0, 0, 0);
    end
    abort = 0;

    // arm during PULSE ignored; no rearm after done
    idle_trig(0);
    for (int t = 0; t <= 24; t++) begin
      tick();
      arm = (t == 0) || (t == 7);
      if (t == 0) set_cfg(0, 6, 1, 1, 3'b011, 1, 0);
      if (t == 7) set_cfg(0, 1, 1, 1, 3'b101, 1, 0);
      if (t == 2) trig_in = 1;
      if (t == 14) trig_in = 0;
      if (t == 16) trig_in = 1;
      #3;
      if (t >= 1)
        chk_out($sformatf("armpulse t%0d", t), (t >= 6 && t <= 11),
                (t <= 11) ? 3'b011 : 3'b000, (t <= 5), (t >= 6 && t <= 11), (t == 12));
    end

    // trigger toggling during DELAY does not restart it
    idle_trig(0);
    for (int t = 0; t <= 20; t++) begin
      tick();
      arm = (t == 0);
      if (t == 0) set_cfg(10, 2, 1, 1, 3'b001, 1, 0);
      if (t == 2) trig_in = 1;
      if (t >= 7 && t <= 12) trig_in = ~trig_in;
      #3;
      if (t >= 1)
        chk_out($sformatf("retrig t%0d", t), (t == 16 || t == 17),
                (t <= 17) ? 3'b001 : 3'b000, (t <= 5), (t >= 6 && t <= 17), (t == 18));
    end

    // falling polarity with zero fields: rising edge ignored, falling fires one 1-cycle pulse
    idle_trig(0);
    for (int t = 0; t <= 19; t++) begin
      tick();
      arm = (t == 0);
      if (t == 0) set_cfg(0, 0, 0, 0, 3'b010, 0, 0);
      if (t == 2) trig_in = 1;
      if (t == 12) trig_in = 0;
      #3;
      if (t >= 1)
        chk_out($sformatf("fall t%0d", t), (t == 16), (t <= 16) ? 3'b010 : 3'b000,
                (t <= 15), (t == 16), (t == 17));
    end

    // reset mid-pulse clears everything on the next edge
    idle_trig(0);
    for (int t = 0; t <= 14; t++) begin
      tick();
      arm   = (t == 0);
      reset = (t == 8);
      if (t == 0) set_cfg(0, 10, 1, 1, 3'b110, 1, 0);
      if (t == 2) trig_in = 1;
      #3;
      if (t == 8) chk("rst pre glitch", o_glitch, 1);
      if (t >= 9) chk_out($sformatf("rst t%0d", t), 0, 0, 0, 0, 0);
    end

`ifdef ARM_TIMEOUT_EN
    idle_trig(0);
    for (int t = 0; t <= 103; t++) begin
      tick();
      arm = (t == 0);
      if (t == 0) set_cfg(0, 1, 1, 1, 3'b101, 1, 100);
      #3;
      if (t >= 1) begin
        chk($sformatf("tmo t%0d timed_out", t), timed_out, (t == 100));
        chk($sformatf("tmo t%0d armed", t), armed, (t <= 100));
        chk($sformatf("tmo t%0d sel", t), o_sel, (t <= 100) ? 3'b101 : 3'b000);
      end
    end
    idle_trig(0);
    for (int t = 0; t <= 104; t++) begin
      tick();
      arm = (t == 0);
      if (t == 0) set_cfg(0, 1, 1, 1, 3'b101, 1, 100);
      if (t == 96) trig_in = 1;
      #3;
      if (t >= 1) begin
        chk($sformatf("tmo99 t%0d timed_out", t), timed_out, 0);
        chk($sformatf("tmo99 t%0d glitch", t), o_glitch, (t == 100));
        chk($sformatf("tmo99 t%0d done", t), done, (t == 101));
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
